// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI master
// Purpose: FSM state type, SPI mode encodings, default parameter values and
// the chip-select index width helper used by spi_master_ctrl.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      XFER,
      HOLD,
      DONE
   } state_e;

   // Mode encoding is {cpol, cpha}
   localparam logic [1:0] SPI_MODE0 = 2'b00;
   localparam logic [1:0] SPI_MODE1 = 2'b01;
   localparam logic [1:0] SPI_MODE2 = 2'b10;
   localparam logic [1:0] SPI_MODE3 = 2'b11;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_DIV_W  = 8;
   localparam int DEF_NUM_CS = 4;

   // A single slave still needs a one-bit select port
   function automatic int cs_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - SCLK divider with leading/trailing edge strobes
// Purpose: divides clk by 2*(div+1) while en is high and reports which SCLK
// edge the next clk edge produces.
// Ports:
//   clk, nrst   system clock, asynchronous active-low reset
//   en          divider running (XFER only)
//   idle_lvl    SCLK idle level (cpol); sclk is parked here while disabled
//   div         half-period minus one, in clk cycles
//   sclk        registered SPI clock
//   lead_edge   this clk edge moves sclk away from idle_lvl
//   trail_edge  this clk edge moves sclk back to idle_lvl
module spi_clk_gen #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             en,
   input  logic             idle_lvl,
   input  logic [DIV_W-1:0] div,
   output logic             sclk,
   output logic             lead_edge,
   output logic             trail_edge
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             sclk_q, sclk_d;
   logic             tick;

   // The strobes are combinational so the top samples/shifts on the very
   // clk edge that registers the new sclk level.
   assign tick       = en && (cnt_q == '0);
   assign lead_edge  = tick && (sclk_q == idle_lvl);
   assign trail_edge = tick && (sclk_q != idle_lvl);
   assign sclk       = sclk_q;

   always_comb begin
      cnt_d  = cnt_q;
      sclk_d = sclk_q;
      if (!en) begin
         cnt_d  = div;
         sclk_d = idle_lvl;
      end else if (tick) begin
         cnt_d  = div;
         sclk_d = ~sclk_q;
      end else begin
         cnt_d  = cnt_q - DIV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - parametrised full-duplex single-word SPI master
// Purpose: FSM, shift registers, bit counter and chip-select decode around
// spi_clk_gen. All outputs are registered.
// Ports:
//   clk, nrst        system clock, asynchronous active-low reset
//   start            one-cycle request, honoured only in IDLE
//   tx_data, cpol, cpha, lsb_first, clk_div, cs_sel   latched on start
//   busy, done       handshake; done pulses with rx_data valid
//   rx_data          last received word
//   sclk, mosi, miso, cs_n   SPI pins
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DIV_W  = DEF_DIV_W,
   parameter int NUM_CS = DEF_NUM_CS,
   parameter int CS_W   = cs_width(NUM_CS)
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              start,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              lsb_first,
   input  logic [DIV_W-1:0]  clk_div,
   input  logic [CS_W-1:0]   cs_sel,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rx_data,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic [NUM_CS-1:0] cs_n
);

   localparam int BCW = $clog2(DATA_W) + 1;

   state_e            state_q, state_d;
   logic              cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
   logic [DIV_W-1:0]  div_q, div_d, cyc_q, cyc_d;
   logic [CS_W-1:0]   cs_q, cs_d;
   logic [DATA_W-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
   logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
   logic              busy_q, busy_d, done_q, done_d, mosi_q, mosi_d;
   logic [NUM_CS-1:0] cs_n_q, cs_n_d;
   logic              lead_edge, trail_edge, sample, drive, last_edge;

   // In IDLE sclk follows the live cpol input so the bus idles correctly
   // before the first transfer; afterwards the latched copy rules.
   spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
      .clk        (clk),
      .nrst       (nrst),
      .en         (state_q == XFER),
      .idle_lvl   ((state_q == IDLE) ? cpol : cpol_q),
      .div        (div_q),
      .sclk       (sclk),
      .lead_edge  (lead_edge),
      .trail_edge (trail_edge)
   );

   assign sample = cpha_q ? trail_edge : lead_edge;
   // bit_cnt counts received bits; with cpha=0 the final trailing edge comes
   // after all bits are in and must not shift out a stale bit.
   assign drive     = cpha_q ? lead_edge : (trail_edge && (bit_cnt_q != BCW'(DATA_W)));
   assign last_edge = trail_edge &&
                      (bit_cnt_q == (cpha_q ? BCW'(DATA_W - 1) : BCW'(DATA_W)));

   always_comb begin
      state_d   = state_q;
      cpol_d    = cpol_q;
      cpha_d    = cpha_q;
      lsb_d     = lsb_q;
      div_d     = div_q;
      cs_d      = cs_q;
      cyc_d     = cyc_q;
      tx_sr_d   = tx_sr_q;
      rx_sr_d   = rx_sr_q;
      rx_data_d = rx_data_q;
      bit_cnt_d = bit_cnt_q;
      mosi_d    = mosi_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            cpol_d    = cpol;
            cpha_d    = cpha;
            lsb_d     = lsb_first;
            div_d     = clk_div;
            cs_d      = cs_sel;
            cyc_d     = clk_div;
            bit_cnt_d = '0;
            tx_sr_d   = tx_data;
            state_d   = SETUP;
            // cpha=0 needs the first bit on the wire before the first edge
            if (!cpha) begin
               mosi_d  = lsb_first ? tx_data[0] : tx_data[DATA_W-1];
               tx_sr_d = lsb_first ? (tx_data >> 1) : (tx_data << 1);
            end
         end
         SETUP: begin
            if (cyc_q == '0) state_d = XFER;
            else             cyc_d   = cyc_q - DIV_W'(1);
         end
         XFER: begin
            if (sample) begin
               rx_sr_d   = lsb_q ? {miso, rx_sr_q[DATA_W-1:1]} : {rx_sr_q[DATA_W-2:0], miso};
               bit_cnt_d = bit_cnt_q + BCW'(1);
            end
            if (drive) begin
               mosi_d  = lsb_q ? tx_sr_q[0] : tx_sr_q[DATA_W-1];
               tx_sr_d = lsb_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
            end
            if (last_edge) begin
               cyc_d   = div_q;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (cyc_q == '0) begin
               state_d   = DONE;
               done_d    = 1'b1;
               rx_data_d = rx_sr_q;
            end else begin
               cyc_d = cyc_q - DIV_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == SETUP) || (state_d == XFER) || (state_d == HOLD);
      // Out-of-range selects match no index, so no slave is addressed
      cs_n_d = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         if (busy_d && (int'(cs_d) == i)) cs_n_d[i] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q   <= IDLE;
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         lsb_q     <= 1'b0;
         div_q     <= '0;
         cs_q      <= '0;
         cyc_q     <= '0;
         tx_sr_q   <= '0;
         rx_sr_q   <= '0;
         rx_data_q <= '0;
         bit_cnt_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         mosi_q    <= 1'b0;
         cs_n_q    <= '1;
      end else begin
         state_q   <= state_d;
         cpol_q    <= cpol_d;
         cpha_q    <= cpha_d;
         lsb_q     <= lsb_d;
         div_q     <= div_d;
         cs_q      <= cs_d;
         cyc_q     <= cyc_d;
         tx_sr_q   <= tx_sr_d;
         rx_sr_q   <= rx_sr_d;
         rx_data_q <= rx_data_d;
         bit_cnt_q <= bit_cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         mosi_q    <= mosi_d;
         cs_n_q    <= cs_n_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign rx_data = rx_data_q;
   assign mosi    = mosi_q;
   assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - directed self-checking bench for spi_master_ctrl
module tb_spi_master_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        nrst, start8, start16, cpol, cpha, lsb, miso;
   logic [7:0]  tx8, clk_div;
   logic [15:0] tx16;
   logic [2:0]  cs_sel;
   logic        busy8, done8, sclk8, mosi8, busy16, done16, sclk16, mosi16;
   logic [7:0]  rx8;
   logic [15:0] rx16;
   logic [3:0]  cs_n8, cs_n16;

   spi_master_ctrl #(.DATA_W(8), .DIV_W(8), .NUM_CS(4), .CS_W(3)) dut8 (
      .clk(clk), .nrst(nrst), .start(start8), .tx_data(tx8), .cpol(cpol), .cpha(cpha),
      .lsb_first(lsb), .clk_div(clk_div), .cs_sel(cs_sel), .busy(busy8), .done(done8),
      .rx_data(rx8), .sclk(sclk8), .mosi(mosi8), .miso(miso), .cs_n(cs_n8));

   spi_master_ctrl #(.DATA_W(16), .DIV_W(8), .NUM_CS(4), .CS_W(3)) dut16 (
      .clk(clk), .nrst(nrst), .start(start16), .tx_data(tx16), .cpol(cpol), .cpha(cpha),
      .lsb_first(lsb), .clk_div(clk_div), .cs_sel(cs_sel), .busy(busy16), .done(done16),
      .rx_data(rx16), .sclk(sclk16), .mosi(mosi16), .miso(miso), .cs_n(cs_n16));

   int checks = 0;
   int errors = 0;

   bit          sel16, loopback;
   int          dw, edges, nb, sidx, ndone;
   logic [15:0] slave_w, mosi_cap;
   logic [3:0]  cs_seen;
   logic        sclk_prev, mosi_first, mosi_last, lead;

   wire       busy_m = sel16 ? busy16 : busy8;
   wire       done_m = sel16 ? done16 : done8;
   wire       sclk_m = sel16 ? sclk16 : sclk8;
   wire       mosi_m = sel16 ? mosi16 : mosi8;
   wire [3:0] cs_n_m = sel16 ? cs_n16 : cs_n8;

   function automatic int bpos(input int i);
      return lsb ? i : dw - 1 - i;
   endfunction

   // Slave model and pin monitor; outputs change on posedge, so negedge sees stable values
   always @(negedge clk) begin
      if (busy_m) begin
         cs_seen = cs_seen | ~cs_n_m;
         if (sclk_m != sclk_prev) begin
            edges++;
            lead = (sclk_prev == cpol);
            if (lead ^ cpha) begin
               if (nb < dw) mosi_cap[bpos(nb)] = mosi_m;
               if (nb == 0) mosi_first = mosi_m;
               mosi_last = mosi_m;
               nb++;
            end
            if (!cpha && !lead) begin
               sidx++;
               if (sidx < dw) miso = slave_w[bpos(sidx)];
            end
            if (cpha && lead) begin
               if (sidx < dw) miso = slave_w[bpos(sidx)];
               sidx++;
            end
         end
      end else begin
         sidx = 0;
         miso = cpha ? 1'b0 : slave_w[bpos(0)];
      end
      if (loopback) miso = mosi_m;
      if (done_m) ndone++;
      sclk_prev = sclk_m;
   end

   task automatic run_xfer(input logic [15:0] tx, input bit disturb, output int lat);
      edges = 0; nb = 0; ndone = 0; cs_seen = 4'h0; mosi_cap = 16'h0;
      tx8 = tx[7:0]; tx16 = tx;
      @(posedge clk); #1;
      if (sel16) start16 = 1'b1; else start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0; start16 = 1'b0;
      lat = 0;
      while (lat < 3000) begin
         @(posedge clk); #1;
         lat++;
         if (disturb && lat == 10) begin
            start8 = 1'b1; cs_sel = 3'd0; tx8 = 8'hFF; clk_div = 8'd0;
         end
         if (disturb && lat == 11) start8 = 1'b0;
         if (done_m) break;
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      nrst = 1'b0; start8 = 0; start16 = 0; cpol = 0; cpha = 0; lsb = 0;
      tx8 = 0; tx16 = 0; clk_div = 8'd1; cs_sel = 0; miso = 0;
      sel16 = 0; loopback = 0; dw = 8; slave_w = 0; sclk_prev = 0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy8); end
      checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done8); end
      checks++; if (rx8 !== 8'h00) begin errors++; $display("FAIL reset_rx got %h exp 00", rx8); end
      checks++; if (sclk8 !== 1'b0 || mosi8 !== 1'b0) begin errors++; $display("FAIL reset_pins sclk %b mosi %b exp 0 0", sclk8, mosi8); end
      checks++; if (cs_n8 !== 4'hF || cs_n16 !== 4'hF) begin errors++; $display("FAIL reset_cs_n got %h/%h exp F/F", cs_n8, cs_n16); end
      nrst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_mode0;
      int lat;
      cpol = 0; cpha = 0; lsb = 0; clk_div = 8'd1; cs_sel = 3'd0; loopback = 1;
      run_xfer(16'h00A5, 0, lat);
      checks++; if (lat !== 36) begin errors++; $display("FAIL m0_latency got %0d exp 36", lat); end
      checks++; if (rx8 !== 8'hA5) begin errors++; $display("FAIL m0_rx got %h exp a5", rx8); end
      checks++; if (mosi_cap[7:0] !== 8'hA5) begin errors++; $display("FAIL m0_mosi got %h exp a5", mosi_cap[7:0]); end
      checks++; if (edges !== 16) begin errors++; $display("FAIL m0_edges got %0d exp 16", edges); end
      checks++; if (cs_seen !== 4'b0001) begin errors++; $display("FAIL m0_cs got %b exp 0001", cs_seen); end
      checks++; if (ndone !== 1) begin errors++; $display("FAIL m0_done_count got %0d exp 1", ndone); end
      loopback = 0;
   endtask

   task automatic test_modes;
      int lat;
      for (int m = 1; m <= 3; m++) begin
         cpol = m[1]; cpha = m[0]; clk_div = 8'(m - 1); slave_w = 16'h00C3;
         repeat (2) @(posedge clk);
         #1;
         checks++; if (sclk8 !== cpol) begin errors++; $display("FAIL mode%0d_idle_sclk got %b exp %b", m, sclk8, cpol); end
         run_xfer(16'h003C, 0, lat);
         checks++; if (rx8 !== 8'hC3) begin errors++; $display("FAIL mode%0d_rx got %h exp c3", m, rx8); end
         checks++; if (mosi_cap[7:0] !== 8'h3C) begin errors++; $display("FAIL mode%0d_mosi got %h exp 3c", m, mosi_cap[7:0]); end
         checks++; if (lat !== m * 18) begin errors++; $display("FAIL mode%0d_latency got %0d exp %0d", m, lat, m * 18); end
         checks++; if (sclk8 !== cpol) begin errors++; $display("FAIL mode%0d_end_sclk got %b exp %b", m, sclk8, cpol); end
      end
      cpol = 0; cpha = 0; clk_div = 8'd1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_lsb16;
      int lat;
      sel16 = 1; dw = 16; lsb = 1; cs_sel = 3'd1; slave_w = 16'h1234;
      repeat (2) @(posedge clk);
      run_xfer(16'h8001, 0, lat);
      checks++; if (rx16 !== 16'h1234) begin errors++; $display("FAIL lsb_rx got %h exp 1234", rx16); end
      checks++; if (mosi_first !== 1'b1 || mosi_last !== 1'b1) begin errors++; $display("FAIL lsb_mosi_ends got %b/%b exp 1/1", mosi_first, mosi_last); end
      checks++; if (mosi_cap !== 16'h8001) begin errors++; $display("FAIL lsb_mosi got %h exp 8001", mosi_cap); end
      checks++; if (lat !== 68 || edges !== 32) begin errors++; $display("FAIL lsb_timing lat %0d edges %0d exp 68 32", lat, edges); end
      checks++; if (cs_seen !== 4'b0010) begin errors++; $display("FAIL lsb_cs got %b exp 0010", cs_seen); end
      sel16 = 0; dw = 8; lsb = 0;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_back_to_back;
      int lat;
      cs_sel = 3'd2; clk_div = 8'd1; loopback = 1;
      run_xfer(16'h0096, 1, lat);
      checks++; if (cs_seen !== 4'b0100) begin errors++; $display("FAIL ignore_cs got %b exp 0100", cs_seen); end
      checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_done_count got %0d exp 1", ndone); end
      checks++; if (rx8 !== 8'h96) begin errors++; $display("FAIL ignore_rx got %h exp 96", rx8); end
      checks++; if (lat !== 36) begin errors++; $display("FAIL ignore_latency got %0d exp 36", lat); end
      clk_div = 8'd1;
   endtask

   task automatic test_cs_oob;
      int lat;
      cs_sel = 3'd5; clk_div = 8'd2; loopback = 1;
      run_xfer(16'h005A, 0, lat);
      checks++; if (cs_seen !== 4'h0) begin errors++; $display("FAIL oob_cs got %b exp 0000", cs_seen); end
      checks++; if (lat !== 54) begin errors++; $display("FAIL oob_latency got %0d exp 54", lat); end
      checks++; if (rx8 !== 8'h5A || ndone !== 1) begin errors++; $display("FAIL oob_rx got %h/%0d exp 5a/1", rx8, ndone); end
      clk_div = 8'd1;
   endtask

   task automatic test_reset_mid;
      int cyc, lat;
      cs_sel = 3'd3; loopback = 1; edges = 0; ndone = 0; tx8 = 8'hC7;
      @(posedge clk); #1; start8 = 1'b1;
      @(posedge clk); #1; start8 = 1'b0;
      cyc = 0;
      while (edges < 8 && cyc < 200) begin
         @(posedge clk); #1; cyc++;
      end
      checks++; if (edges < 8) begin errors++; $display("FAIL rst_mid_reach got %0d edges exp 8", edges); end
      #2 nrst = 1'b0;
      #1;
      checks++; if (cs_n8 !== 4'hF || sclk8 !== 1'b0) begin errors++; $display("FAIL rst_mid_pins cs_n %h sclk %b exp F 0", cs_n8, sclk8); end
      checks++; if (busy8 !== 1'b0 || rx8 !== 8'h00) begin errors++; $display("FAIL rst_mid_state busy %b rx %h exp 0 00", busy8, rx8); end
      repeat (3) @(posedge clk);
      #1 nrst = 1'b1;
      repeat (50) @(posedge clk);
      #1;
      checks++; if (ndone !== 0 || busy8 !== 1'b0) begin errors++; $display("FAIL rst_mid_nodone done %0d busy %b exp 0 0", ndone, busy8); end
      run_xfer(16'h003E, 0, lat);
      checks++; if (rx8 !== 8'h3E || lat !== 36) begin errors++; $display("FAIL rst_mid_recover rx %h lat %0d exp 3e 36", rx8, lat); end
      loopback = 0;
   endtask

   initial begin
      test_reset;
      test_mode0;
      test_modes;
      test_lsb16;
      test_back_to_back;
      test_cs_oob;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

Parametrised SPI master that generalises the fixed 8-bit, fixed-mode shifter. It adds configurable word width, all four CPOL/CPHA modes, MSB/LSB-first ordering, a programmable SCLK divider, multiple chip selects and a start/busy/done handshake. It sits between a register-level host and the external SPI pins, and runs full-duplex single-word transfers.

## Interface
- DATA_W, 8: bits per transfer word (≥2)
- DIV_W, 8: width of the clock-divider input
- NUM_CS, 4: number of chip-select outputs (≥1)
- CS_W, $clog2(NUM_CS) (min 1): width of cs_sel
---
- clk  in  1  system clock; all logic on rising edge
- nrst  in  1  asynchronous active-low reset
- start  in  1  one-cycle transfer request
- tx_data  in  DATA_W  word to transmit
- cpol  in  1  SCLK idle level
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
- lsb_first  in  1  bit order
- clk_div  in  DIV_W  SCLK half-period minus 1, in clk cycles
- cs_sel  in  CS_W  target slave index
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse; rx_data valid
- rx_data  out  DATA_W  last received word
- sclk  out  1  SPI clock
- mosi  out  1  serial data out
- miso  in  1  serial data in
- cs_n  out  NUM_CS  active-low chip selects

## Operation
- States: IDLE → SETUP → XFER → HOLD → DONE → IDLE.
- IDLE:
  - busy=0; sclk tracks cpol, registered.
  - start=1 latches tx_data, cpol, cpha, lsb_first, clk_div and cs_sel, then moves to SETUP.
- Let N = clk_div+1.
- SETUP (N cycles):
  - cs_n[cs_sel]=0; sclk=cpol.
  - If cpha=0, mosi is driven with the first bit at SETUP entry.
- XFER (2·DATA_W·N cycles):
  - sclk toggles every N cycles, giving 2·DATA_W edges, alternating leading and trailing.
  - cpha=0: sample miso on leading edges; shift mosi on trailing edges, except the last one.
  - cpha=1: drive mosi on leading edges; sample miso on trailing edges.
  - First bit is tx_data[DATA_W-1] (lsb_first=0) or tx_data[0] (lsb_first=1). Received bits are assembled in the same order.
- HOLD (N cycles): sclk=cpol; chip select still asserted.
- DONE (1 cycle):
  - All cs_n high; done=1; busy=0.
  - rx_data is updated on entry and held until the next DONE.
- Latched configuration is immune to input changes during a transfer.
- start while busy=1 is ignored; no queuing.
- start in the DONE cycle is ignored.
- cs_sel ≥ NUM_CS: the transfer runs, but no cs_n is asserted.
- Bit counter width is $clog2(DATA_W)+1. The divider counter wraps at clk_div with no overflow.
- clk_div=0 gives SCLK = clk/2.

## Timing
- Reset values:
  - busy=0, done=0, rx_data=0
  - sclk=0, mosi=0, cs_n=all 1
  - state=IDLE
- Reset is asynchronous and active anywhere mid-transfer. It aborts immediately to the reset values. There is no done pulse and rx_data is cleared.
- All outputs are registered.
- With start sampled at edge T:
  - busy=1 and cs_n asserted from T+1.
  - done is asserted in cycle T + 1 + N·(2·DATA_W+2).
- Example, DATA_W=8, clk_div=1: done at T+37.
- Sampled miso is the value at the clk edge coincident with the sampling SCLK edge.

## Structure
- Package spi_pkg:
  - state enum (IDLE, SETUP, XFER, HOLD, DONE)
  - mode constants SPI_MODE0..3 = {cpol,cpha}
  - default parameter values
- Sub-module spi_clk_gen, instantiated once:
  - down-counter loaded from the latched clk_div
  - emits one-cycle lead_edge and trail_edge strobes, and the toggled sclk
  - enabled only in XFER
- The top level holds the FSM, shift registers, bit counter and CS decode.

## Test plan
- Mode 0, DATA_W=8, clk_div=1, tx_data=0xA5, miso loopback → 16 sclk edges; mosi pattern 1010_0101 MSB-first; rx_data=0xA5; done at T+37.
- Modes 1/2/3 each, tx_data=0x3C, slave model returning 0xC3 → rx_data=0xC3; idle sclk equals cpol; sampling edge matches cpha.
- lsb_first=1, DATA_W=16, tx_data=0x8001 → mosi first bit 1, last bit 1; slave sends 0x1234 LSB-first → rx_data=0x1234.
- start pulsed again mid-transfer, and cs_sel changed mid-transfer → ignored; only the latched cs_n[2] is asserted; exactly one done.
- nrst low during XFER bit 4 → in the same cycle cs_n=all 1, sclk=0, busy=0, rx_data=0; no done; next start completes normally.
- cs_sel=5 with NUM_CS=4 → cs_n stays 0xF throughout; done still pulses at the computed cycle.
